cpu_icache: RTL and testbench
=============================

CPU_ICACHE -- requirements
Module: cpu_icache

Interface
Parameters:
REQ-001 The block SHALL take parameter NUM_LINES, default 4, as the number of direct-mapped lines (power of 2).
REQ-002 The block SHALL take parameter WORDS_PER_LINE, default 4, as the number of 32-bit words per line (power of 2).
REQ-003 The block SHALL take parameter ADDR_W, default 32, as the byte-address width.

Ports:
REQ-004 clock  in  1  single clock; all state SHALL change on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 fetch_req  in  1  fetch stage requests the instruction at fetch_addr this cycle.
REQ-007 fetch_addr  in  ADDR_W  byte address of the instruction (PC); bits [1:0] are ignored.
REQ-008 fetch_instr  out  32  instruction word returned to fetch.
REQ-009 fetch_valid  out  1  fetch_instr is valid this cycle.
REQ-010 stall  out  1  stall request to the hazard-detection unit; fetch holds PC while it is high.
REQ-011 flush  in  1  invalidate all lines.
REQ-012 mem_req  out  1  line refill request to instruction memory.
REQ-013 mem_addr  out  ADDR_W  line-aligned refill address.
REQ-014 mem_ready  in  1  memory returns the line this cycle.
REQ-015 mem_rdata  in  32*WORDS_PER_LINE  refill line; word 0 is in the LSBs.
REQ-016 hit_count  out  16  saturating hit counter.
REQ-017 miss_count  out  16  saturating miss counter.

Function
REQ-018 Address split: offset = addr[log2(WORDS_PER_LINE)+1:2]; index = the next log2(NUM_LINES) bits; tag = the remaining upper bits.
REQ-019 Storage: per line, a valid bit, a tag and WORDS_PER_LINE words.
REQ-020 FSM states SHALL be IDLE, MISS and DRAIN; the reset state SHALL be IDLE.
REQ-021 Hit in IDLE (fetch_req, line valid, tag match): fetch_valid=1 and fetch_instr=word[offset] in the same cycle (combinational); stall=0; hit_count increments.
REQ-022 Miss in IDLE (fetch_req with the line invalid or a tag mismatch): fetch_valid=0 and stall=1 combinationally; miss_count increments; the line address is latched; the FSM goes to MISS.
REQ-023 In MISS, mem_req=1, mem_addr holds the latched line address, and stall=1.
REQ-024 On mem_ready in MISS: write mem_rdata to the line, set its tag and valid bit, and go to IDLE.
REQ-025 The refilled access is replayed in IDLE on the next cycle and hits, so minimum miss latency = mem latency + 1 cycle.
REQ-026 mem_req SHALL stay high until mem_ready, and at most one refill SHALL be outstanding.
REQ-027 mem_ready outside MISS/DRAIN SHALL be ignored.
REQ-028 Flush in IDLE: clear all valid bits at the clock edge; a lookup in the same cycle is treated as a miss (fetch_valid=0, stall=1).
REQ-029 Flush in MISS: go to DRAIN. In DRAIN, mem_req stays 1 and stall=1; on mem_ready the data is discarded (line not validated) and the FSM goes to IDLE.
REQ-030 Flush together with mem_ready in MISS: data is discarded; go to IDLE.
REQ-031 fetch_req=0: fetch_valid=0, stall=0 in IDLE, and no counter changes.
REQ-032 Counters saturate at 0xFFFF with no wrap; only IDLE lookups are counted (replays count as hits).
REQ-033 Refill to an occupied index overwrites that line (direct-mapped; no victim handling).

Reset
REQ-034 reset low SHALL clear asynchronously: FSM=IDLE, all valid bits=0, mem_req=0, stall=0, fetch_valid=0, fetch_instr=0, hit_count=0, miss_count=0.
REQ-035 Reset during MISS/DRAIN SHALL abandon the refill; a mem_ready after reset release is ignored.
REQ-036 Data and tag arrays need not be reset.

Verification
REQ-037 Cold miss: after reset, fetch_req with addr 0x00000004 -> stall=1 and mem_req=1 with mem_addr 0x00000000; mem_ready after 3 cycles with line {0x44,0x33,0x22,0x11} -> next cycle fetch_valid=1, fetch_instr=0x22; miss_count=1, hit_count=1.
REQ-038 Sequential hits: then addr 0x08 and 0x0C -> fetch_valid=1 in the same cycle, instr 0x33 and 0x44; stall=0; hit_count=3.
REQ-039 Conflict: addr 0x40 (same index 0, tag 1) -> miss with mem_addr 0x40; after refill, addr 0x00 misses again; miss_count=3.
REQ-040 Flush mid-miss: flush one cycle after a miss -> DRAIN; mem_req held until mem_ready; the same address then misses again with a second mem_req.
REQ-041 Reset mid-miss: reset low while mem_req=1 -> mem_req=0 immediately (asynchronous); a later mem_ready causes no line to become valid.
REQ-042 Saturation: force 65536 hits -> hit_count stays 0xFFFF.

Source files
------------

// File: rtl/cpu_icache_if.sv
// Fetch-side and memory-side signal bundle for the instruction cache.
//
// Handshake semantics: fetch_req is a per-cycle request; the cache answers
// in the same cycle with fetch_valid (instruction returned) or stall (hold
// the PC and re-present the same request). On the memory side, mem_req is a
// level that stays high from the first refill cycle until the cycle
// mem_ready is seen; mem_ready qualifies mem_rdata for exactly that cycle.
interface cpu_icache_if #(
    parameter int ADDR_W         = 32,
    parameter int WORDS_PER_LINE = 4
);
    logic                        fetch_req;
    logic [ADDR_W-1:0]           fetch_addr;
    logic [31:0]                 fetch_instr;
    logic                        fetch_valid;
    logic                        stall;
    logic                        flush;
    logic                        mem_req;
    logic [ADDR_W-1:0]           mem_addr;
    logic                        mem_ready;
    logic [32*WORDS_PER_LINE-1:0] mem_rdata;

    // Cache side.
    modport slave (
        input  fetch_req, fetch_addr, flush, mem_ready, mem_rdata,
        output fetch_instr, fetch_valid, stall, mem_req, mem_addr
    );

    // Fetch stage / instruction memory side.
    modport master (
        output fetch_req, fetch_addr, flush, mem_ready, mem_rdata,
        input  fetch_instr, fetch_valid, stall, mem_req, mem_addr
    );
endinterface

// File: rtl/cpu_icache.sv
// Direct-mapped instruction cache with single outstanding line refill,
// flush/drain handling and saturating hit/miss counters.
module cpu_icache #(
    parameter int NUM_LINES      = 4,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic        clock,
    input  logic        reset,
    cpu_icache_if.slave bus,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count,
    output logic [1:0]  state_dbg
);
    localparam int OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int IDX_W   = $clog2(NUM_LINES);
    localparam int TAG_LSB = OFF_W + IDX_W + 2;
    localparam int TAG_W   = ADDR_W - TAG_LSB;
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((64'd1 << (OFF_W + 2)) - 64'd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MISS  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_next;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][WORDS_PER_LINE];
    logic [ADDR_W-1:0]    line_addr_q;

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             lookup_hit;
    logic             hit;
    logic             miss;
    logic             refill_we;
    logic             unused_addr_bits;

    assign off      = bus.fetch_addr[OFF_W+1:2];
    assign idx      = bus.fetch_addr[TAG_LSB-1:OFF_W+2];
    assign tag      = bus.fetch_addr[ADDR_W-1:TAG_LSB];
    assign fill_idx = line_addr_q[TAG_LSB-1:OFF_W+2];
    assign fill_tag = line_addr_q[ADDR_W-1:TAG_LSB];

    // Instructions are word aligned; the byte-select bits carry no information.
    assign unused_addr_bits = ^bus.fetch_addr[1:0];

    // A flush in the lookup cycle forces a miss even if the line is resident.
    assign lookup_hit = bus.fetch_req && !bus.flush && valid_q[idx] && (tag_q[idx] == tag);
    assign hit        = (state == IDLE) && lookup_hit;
    assign miss       = (state == IDLE) && bus.fetch_req && !lookup_hit;
    // Refill data is dropped whenever a flush coincides with or precedes it.
    assign refill_we  = (state == MISS) && bus.mem_ready && !bus.flush;

    assign state_dbg = state;

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (miss) state_next = MISS;
            MISS: begin
                if (bus.mem_ready)  state_next = IDLE;
                else if (bus.flush) state_next = DRAIN;
            end
            DRAIN:   if (bus.mem_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: combinational hit path in IDLE, refill request otherwise.
    always_comb begin
        bus.fetch_valid = 1'b0;
        bus.fetch_instr = 32'd0;
        bus.stall       = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_addr    = '0;
        case (state)
            IDLE: begin
                bus.fetch_valid = hit;
                bus.fetch_instr = hit ? data_q[idx][off] : 32'd0;
                bus.stall       = miss;
            end
            MISS, DRAIN: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = line_addr_q;
                bus.stall    = 1'b1;
            end
            default: ;
        endcase
    end

    // Valid bits: flush wins over a same-cycle refill.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (bus.flush) begin
            valid_q <= '0;
        end else if (refill_we) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Miss address latch and tag/data arrays; contents are qualified by valid_q.
    always_ff @(posedge clock) begin
        if (miss) line_addr_q <= bus.fetch_addr & ~LINE_MASK;
        if (refill_we) begin
            tag_q[fill_idx] <= fill_tag;
            for (int w = 0; w < WORDS_PER_LINE; w++) begin
                data_q[fill_idx][w] <= bus.mem_rdata[w*32 +: 32];
            end
        end
    end

    // Saturating hit/miss counters; only IDLE lookups are counted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count  <= 16'd0;
            miss_count <= 16'd0;
        end else begin
            if (hit && hit_count != 16'hFFFF)   hit_count  <= hit_count + 16'd1;
            if (miss && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_cpu_icache.sv
// Directed bench for cpu_icache: cold miss, sequential hits, conflict miss,
// flush in IDLE/MISS, reset mid-refill and hit counter saturation.
module tb_cpu_icache;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MISS  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [127:0] LINE_A = {32'h44, 32'h33, 32'h22, 32'h11};
    localparam logic [127:0] LINE_B = {32'hD4, 32'hC4, 32'hB4, 32'hA4};
    localparam logic [127:0] LINE_J = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};

    logic        clock;
    logic        reset;
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    logic [1:0]  state_dbg;
    int          checks_n;
    int          errors_n;
    logic [31:0] exp_q[$];

    cpu_icache_if #(.ADDR_W(32), .WORDS_PER_LINE(4)) bus ();

    cpu_icache #(.NUM_LINES(4), .WORDS_PER_LINE(4), .ADDR_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus.slave),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .state_dbg  (state_dbg)
    );

    // Clock generation.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            errors_n++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Stimulus and checks. Inputs change at the falling edge, outputs are
    // sampled 1 time unit later, well away from the rising edge.
    initial begin
        checks_n       = 0;
        errors_n       = 0;
        reset          = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = 32'd0;
        bus.flush      = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
        #3;
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_valid", 32'(bus.fetch_valid), 32'd0);
        check("rst_instr", bus.fetch_instr, 32'd0);
        check("rst_hits", 32'(hit_count), 32'd0);
        check("rst_misses", 32'(miss_count), 32'd0);
        tick(2);
        reset = 1'b1;

        // Cold miss on 0x04, refill after three cycles in MISS.
        tick(1);
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h4; #1;
        check("cold_stall", 32'(bus.stall), 32'd1);
        check("cold_valid", 32'(bus.fetch_valid), 32'd0);
        tick(1); #1;
        check("cold_state", 32'(state_dbg), 32'(S_MISS));
        check("cold_mem_req", 32'(bus.mem_req), 32'd1);
        check("cold_mem_addr", bus.mem_addr, 32'h0);
        check("cold_misses", 32'(miss_count), 32'd1);
        tick(2);
        bus.mem_ready = 1'b1; bus.mem_rdata = LINE_A; #1;
        check("cold_req_held", 32'(bus.mem_req), 32'd1);
        tick(1);
        bus.mem_ready = 1'b0; #1;
        check("replay_state", 32'(state_dbg), 32'(S_IDLE));
        check("replay_valid", 32'(bus.fetch_valid), 32'd1);
        check("replay_instr", bus.fetch_instr, 32'h22);
        check("replay_stall", 32'(bus.stall), 32'd0);
        tick(1); #1;
        check("replay_hits", 32'(hit_count), 32'd1);
        check("replay_misses", 32'(miss_count), 32'd1);

        // Sequential hits on 0x08 and 0x0C.
        exp_q.push_back(32'h33);
        exp_q.push_back(32'h44);
        for (int i = 0; i < 2; i++) begin
            bus.fetch_addr = 32'h8 + 32'(4 * i); #1;
            check("seq_valid", 32'(bus.fetch_valid), 32'd1);
            check("seq_stall", 32'(bus.stall), 32'd0);
            check("seq_instr", bus.fetch_instr, exp_q.pop_front());
            tick(1);
        end
        bus.fetch_req = 1'b0; #1;
        check("seq_hits", 32'(hit_count), 32'd3);
        check("idle_valid", 32'(bus.fetch_valid), 32'd0);
        check("idle_stall", 32'(bus.stall), 32'd0);

        // Stray mem_ready in IDLE is ignored.
        bus.mem_ready = 1'b1; bus.mem_rdata = LINE_J;
        tick(1);
        bus.mem_ready = 1'b0; #1;
        check("stray_state", 32'(state_dbg), 32'(S_IDLE));
        check("stray_mem_req", 32'(bus.mem_req), 32'd0);

        // Conflict: 0x40 evicts line 0, then 0x00 misses again.
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h40; #1;
        check("conf_stall", 32'(bus.stall), 32'd1);
        check("conf_valid", 32'(bus.fetch_valid), 32'd0);
        tick(1); #1;
        check("conf_mem_addr", bus.mem_addr, 32'h40);
        check("conf_misses", 32'(miss_count), 32'd2);
        bus.mem_ready = 1'b1; bus.mem_rdata = LINE_B;
        tick(1);
        bus.mem_ready = 1'b0; #1;
        check("conf_instr", bus.fetch_instr, 32'hA4);
        tick(1);
        bus.fetch_addr = 32'h0; #1;
        check("evict_stall", 32'(bus.stall), 32'd1);
        check("evict_valid", 32'(bus.fetch_valid), 32'd0);
        tick(1); #1;
        check("evict_mem_addr", bus.mem_addr, 32'h0);
        check("evict_misses", 32'(miss_count), 32'd3);
        bus.mem_ready = 1'b1; bus.mem_rdata = LINE_A;
        tick(1);
        bus.mem_ready = 1'b0; #1;
        check("evict_instr", bus.fetch_instr, 32'h11);
        tick(1); #1;
        check("evict_hits", 32'(hit_count), 32'd5);

        // Flush in IDLE turns a resident lookup into a miss.
        bus.flush = 1'b1; #1;
        check("fl_idle_valid", 32'(bus.fetch_valid), 32'd0);
        check("fl_idle_stall", 32'(bus.stall), 32'd1);
        tick(1);
        bus.flush = 1'b0; #1;
        check("fl_idle_state", 32'(state_dbg), 32'(S_MISS));
        check("fl_idle_misses", 32'(miss_count), 32'd4);

        // Flush one cycle into the miss: DRAIN, data discarded, miss again.
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0; #1;
        check("drain_state", 32'(state_dbg), 32'(S_DRAIN));
        check("drain_mem_req", 32'(bus.mem_req), 32'd1);
        check("drain_stall", 32'(bus.stall), 32'd1);
        tick(1); #1;
        check("drain_held", 32'(bus.mem_req), 32'd1);
        bus.mem_ready = 1'b1; bus.mem_rdata = LINE_A;
        tick(1);
        bus.mem_ready = 1'b0; #1;
        check("drain_done", 32'(state_dbg), 32'(S_IDLE));
        check("drain_discard", 32'(bus.fetch_valid), 32'd0);
        check("drain_restall", 32'(bus.stall), 32'd1);
        tick(1); #1;
        check("remiss_state", 32'(state_dbg), 32'(S_MISS));
        check("remiss_mem_req", 32'(bus.mem_req), 32'd1);
        check("remiss_misses", 32'(miss_count), 32'd5);

        // Flush together with mem_ready in MISS: discard and return to IDLE.
        bus.flush = 1'b1; bus.mem_ready = 1'b1; bus.mem_rdata = LINE_A;
        tick(1);
        bus.flush = 1'b0; bus.mem_ready = 1'b0; #1;
        check("flrdy_state", 32'(state_dbg), 32'(S_IDLE));
        check("flrdy_valid", 32'(bus.fetch_valid), 32'd0);
        check("flrdy_stall", 32'(bus.stall), 32'd1);
        tick(1); #1;
        check("flrdy_misses", 32'(miss_count), 32'd6);

        // Reset while the refill is outstanding.
        reset = 1'b0; bus.fetch_req = 1'b0; #1;
        check("rmid_mem_req", 32'(bus.mem_req), 32'd0);
        check("rmid_state", 32'(state_dbg), 32'(S_IDLE));
        check("rmid_stall", 32'(bus.stall), 32'd0);
        check("rmid_misses", 32'(miss_count), 32'd0);
        tick(1);
        reset = 1'b1;
        tick(1);
        bus.mem_ready = 1'b1; bus.mem_rdata = LINE_A;
        tick(1);
        bus.mem_ready = 1'b0; #1;
        check("rmid_late_state", 32'(state_dbg), 32'(S_IDLE));
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0; #1;
        check("rmid_no_line", 32'(bus.fetch_valid), 32'd0);
        check("rmid_stall2", 32'(bus.stall), 32'd1);
        tick(1); #1;
        check("rmid_misses2", 32'(miss_count), 32'd1);
        bus.mem_ready = 1'b1; bus.mem_rdata = LINE_A;
        tick(1);
        bus.mem_ready = 1'b0; #1;
        check("sat_first_instr", bus.fetch_instr, 32'h11);

        // Saturation: 65535 hits reach 0xFFFF, further hits do not wrap.
        tick(65535); #1;
        check("sat_reach", 32'(hit_count), 32'hFFFF);
        tick(5); #1;
        check("sat_hold", 32'(hit_count), 32'hFFFF);
        check("sat_misses", 32'(miss_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end
endmodule
